// File: rtl/pipe_pkg.sv
// Shared definitions for the 5-stage forwarding / predict-not-taken core.
// - 5-bit opcode-class codes (instr[6:2]). The immediate generator, the
//   register-use decoder and the hazard controller all use these.
// - The canonical NOP encoding (addi x0,x0,0). Pipeline registers load it
//   when they are flushed.
// - The hazard-controller state type.
package pipe_pkg;

    localparam logic [4:0] OPC_R  = 5'b01100;  // register-register ALU
    localparam logic [4:0] OPC_I  = 5'b00100;  // register-immediate ALU
    localparam logic [4:0] OPC_S  = 5'b01000;  // store
    localparam logic [4:0] OPC_L  = 5'b00000;  // load
    localparam logic [4:0] OPC_SB = 5'b11000;  // conditional branch
    localparam logic [4:0] OPC_UL = 5'b01101;  // LUI
    localparam logic [4:0] OPC_UA = 5'b00101;  // AUIPC
    localparam logic [4:0] OPC_UJ = 5'b11011;  // JAL
    localparam logic [4:0] OPC_IJ = 5'b11001;  // JALR

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // The opcode class is the major opcode with the always-11 low bits dropped.
    function automatic logic [4:0] opc_class(input logic [31:0] instr);
        return instr[6:2];
    endfunction

endpackage

// File: rtl/reg_use_decode.sv
// Register-use decoder. Reports which source registers an instruction reads,
// and gives their indices. Purely combinational. The forwarding unit can
// reuse it.
// Ports:
//   instr    in  [31:0]  instruction word
//   uses_rs1 out         instruction reads rs1
//   uses_rs2 out         instruction reads rs2
//   rs1      out [4:0]   rs1 field (valid only when uses_rs1)
//   rs2      out [4:0]   rs2 field (valid only when uses_rs2)
module reg_use_decode
    import pipe_pkg::*;
(
    input  logic [31:0] instr,
    output logic        uses_rs1,
    output logic        uses_rs2,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2
);

    logic [4:0] opc;
    logic       unused_bits;

    assign opc = opc_class(instr);
    assign rs1 = instr[19:15];
    assign rs2 = instr[24:20];

    // Only the opcode and the two source fields matter here.
    assign unused_bits = ^{instr[31:25], instr[14:7], instr[1:0]};

    always_comb begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (opc)
            OPC_R, OPC_S, OPC_SB: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OPC_I, OPC_L, OPC_IJ: begin
                uses_rs1 = 1'b1;
            end
            // U-type and JAL carry immediates in the rs fields. An aliasing
            // match there must not create a false hazard.
            OPC_UL, OPC_UA, OPC_UJ: begin
                uses_rs1 = 1'b0;
                uses_rs2 = 1'b0;
            end
            default: begin
                uses_rs1 = 1'b0;
                uses_rs2 = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline control for the 5-stage forwarding / predict-not-taken core.
// - Holds the pipeline in a flush sequence for BOOT_CYCLES cycles after reset.
// - Freezes everything while data memory is busy.
// - Applies EX-resolved redirects (taken branch / JAL / JALR).
// - Inserts one bubble per load-use hazard.
// - Keeps saturating debug counters of bubbles and redirects.
// Control outputs are combinational from state and inputs, so they act in
// the same cycle.
// Ports:
//   i_clk, i_reset          clock; synchronous active-high reset
//   i_id_instr              instruction in IF/ID
//   i_ex_rd, i_ex_memrd     EX destination register; EX instruction is a load
//   i_ex_redirect           EX resolved a taken control transfer
//   i_mem_stall             data memory busy, hold the whole pipeline
//   o_pc_en, o_pc_sel       PC write enable; select redirect target
//   o_if_id_en/_flush       IF/ID enable; clear IF/ID to NOP
//   o_id_ex_en/_flush       ID/EX enable; clear ID/EX to bubble
//   o_ex_mem_en             EX/MEM and MEM/WB enable
//   o_booting               high while in BOOT
//   o_stall_cnt, o_flush_cnt  saturating event counters
module pipeline_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int BOOT_CYCLES = 3,
    parameter int CNT_W       = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [31:0]      i_id_instr,
    input  logic [4:0]       i_ex_rd,
    input  logic             i_ex_memrd,
    input  logic             i_ex_redirect,
    input  logic             i_mem_stall,
    output logic             o_pc_en,
    output logic             o_pc_sel,
    output logic             o_if_id_en,
    output logic             o_if_id_flush,
    output logic             o_id_ex_en,
    output logic             o_id_ex_flush,
    output logic             o_ex_mem_en,
    output logic             o_booting,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    localparam logic [3:0] BOOT_INIT = 4'(BOOT_CYCLES - 1);

    state_t           state_reg;
    logic [3:0]       boot_cnt_reg;
    logic [CNT_W-1:0] stall_cnt_reg;
    logic [CNT_W-1:0] flush_cnt_reg;

    logic       uses_rs1;
    logic       uses_rs2;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       load_use;
    logic       stall_evt;
    logic       flush_evt;

    reg_use_decode u_reg_use_decode (
        .instr    (i_id_instr),
        .uses_rs1 (uses_rs1),
        .uses_rs2 (uses_rs2),
        .rs1      (rs1),
        .rs2      (rs2)
    );

    // x0 is never a real producer, so a load to x0 cannot create a hazard.
    assign load_use = i_ex_memrd && (i_ex_rd != 5'd0) &&
                      ((uses_rs1 && (rs1 == i_ex_rd)) ||
                       (uses_rs2 && (rs2 == i_ex_rd)));

    always_comb begin
        o_pc_en       = 1'b1;
        o_pc_sel      = 1'b0;
        o_if_id_en    = 1'b1;
        o_if_id_flush = 1'b0;
        o_id_ex_en    = 1'b1;
        o_id_ex_flush = 1'b0;
        o_ex_mem_en   = 1'b1;
        o_booting     = 1'b0;
        stall_evt     = 1'b0;
        flush_evt     = 1'b0;
        if (state_reg == ST_BOOT) begin
            // Fill the front end with NOPs while the PC stays at its reset value.
            o_pc_en       = 1'b0;
            o_if_id_flush = 1'b1;
            o_id_ex_flush = 1'b1;
            o_booting     = 1'b1;
        end else if (i_mem_stall) begin
            // Full freeze. A pending redirect or hazard stays in its
            // register and is handled when the stall drops.
            o_pc_en     = 1'b0;
            o_if_id_en  = 1'b0;
            o_id_ex_en  = 1'b0;
            o_ex_mem_en = 1'b0;
        end else if (i_ex_redirect) begin
            // Flushing IF/ID also removes any load-use instruction in ID.
            o_pc_sel      = 1'b1;
            o_if_id_flush = 1'b1;
            o_id_ex_flush = 1'b1;
            flush_evt     = 1'b1;
        end else if (load_use) begin
            // One bubble is enough. Next cycle the load is in MEM and
            // forwarding supplies the value.
            o_pc_en       = 1'b0;
            o_if_id_en    = 1'b0;
            o_id_ex_flush = 1'b1;
            stall_evt     = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg     <= ST_BOOT;
            boot_cnt_reg  <= BOOT_INIT;
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            case (state_reg)
                ST_BOOT: begin
                    if (boot_cnt_reg == 4'd0) begin
                        state_reg <= ST_RUN;
                    end else begin
                        boot_cnt_reg <= boot_cnt_reg - 4'd1;
                    end
                end
                ST_RUN: begin
                    if (stall_evt && (stall_cnt_reg != '1)) begin
                        stall_cnt_reg <= stall_cnt_reg + 1'b1;
                    end
                    if (flush_evt && (flush_cnt_reg != '1)) begin
                        flush_cnt_reg <= flush_cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= ST_BOOT;
            endcase
        end
    end

    assign o_stall_cnt = stall_cnt_reg;
    assign o_flush_cnt = flush_cnt_reg;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;
    import pipe_pkg::*;

    // Instruction encodings used by the vectors below.
    localparam logic [31:0] ADD_X6_X5_X7 = 32'h0072_8333;  // rs1=5, rs2=7
    localparam logic [31:0] LUI_X5       = 32'h1234_52B7;  // no rs use
    localparam logic [31:0] ADDI_X1_X0_1 = 32'h0010_0093;  // rs1=x0
    localparam logic [31:0] ADDI_X1_X2_5 = 32'h0051_0093;  // rs1=2, imm bits alias rs2=5
    localparam logic [31:0] SW_X5_0_X2   = 32'h0051_2023;  // rs1=2, rs2=5

    // Control vector order: {pc_en, pc_sel, if_id_en, if_id_flush,
    //                        id_ex_en, id_ex_flush, ex_mem_en, booting}
    localparam logic [7:0] C_BOOT   = 8'b0011_1111;
    localparam logic [7:0] C_NORMAL = 8'b1010_1010;
    localparam logic [7:0] C_BUBBLE = 8'b0000_1110;
    localparam logic [7:0] C_REDIR  = 8'b1111_1110;
    localparam logic [7:0] C_FREEZE = 8'b0000_0000;

    logic        clk;
    logic        rst;
    logic [31:0] id_instr;
    logic [4:0]  ex_rd;
    logic        ex_memrd;
    logic        ex_redirect;
    logic        mem_stall;

    logic        pc_en, pc_sel, if_id_en, if_id_flush;
    logic        id_ex_en, id_ex_flush, ex_mem_en, booting;
    logic [15:0] stall_cnt, flush_cnt;

    logic        n_pc_en, n_pc_sel, n_if_id_en, n_if_id_flush;
    logic        n_id_ex_en, n_id_ex_flush, n_ex_mem_en, n_booting;
    logic [1:0]  n_stall_cnt, n_flush_cnt;

    logic [7:0]  ctrl_vec;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    pipeline_hazard_ctrl #(.BOOT_CYCLES(3), .CNT_W(16)) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_id_instr    (id_instr),
        .i_ex_rd       (ex_rd),
        .i_ex_memrd    (ex_memrd),
        .i_ex_redirect (ex_redirect),
        .i_mem_stall   (mem_stall),
        .o_pc_en       (pc_en),
        .o_pc_sel      (pc_sel),
        .o_if_id_en    (if_id_en),
        .o_if_id_flush (if_id_flush),
        .o_id_ex_en    (id_ex_en),
        .o_id_ex_flush (id_ex_flush),
        .o_ex_mem_en   (ex_mem_en),
        .o_booting     (booting),
        .o_stall_cnt   (stall_cnt),
        .o_flush_cnt   (flush_cnt)
    );

    // Narrow-counter copy driven by the same stimulus. It checks saturation.
    pipeline_hazard_ctrl #(.BOOT_CYCLES(3), .CNT_W(2)) dut_narrow (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_id_instr    (id_instr),
        .i_ex_rd       (ex_rd),
        .i_ex_memrd    (ex_memrd),
        .i_ex_redirect (ex_redirect),
        .i_mem_stall   (mem_stall),
        .o_pc_en       (n_pc_en),
        .o_pc_sel      (n_pc_sel),
        .o_if_id_en    (n_if_id_en),
        .o_if_id_flush (n_if_id_flush),
        .o_id_ex_en    (n_id_ex_en),
        .o_id_ex_flush (n_id_ex_flush),
        .o_ex_mem_en   (n_ex_mem_en),
        .o_booting     (n_booting),
        .o_stall_cnt   (n_stall_cnt),
        .o_flush_cnt   (n_flush_cnt)
    );

    assign ctrl_vec = {pc_en, pc_sel, if_id_en, if_id_flush,
                       id_ex_en, id_ex_flush, ex_mem_en, booting};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Inputs change at the falling edge and outputs are sampled 1 ns later.
    task automatic drive(input logic r, input logic memrd, input logic [4:0] rd,
                         input logic [31:0] instr, input logic redir,
                         input logic stall);
        rst         = r;
        ex_memrd    = memrd;
        ex_rd       = rd;
        id_instr    = instr;
        ex_redirect = redir;
        mem_stall   = stall;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_ctrl(input string tag, input logic [7:0] exp);
        #1;
        check_val(tag, {24'd0, ctrl_vec}, {24'd0, exp});
    endtask

    task automatic check_cnts(input string tag, input int exp_stall,
                              input int exp_flush);
        check_val({tag, "_stall"}, {16'd0, stall_cnt}, 32'(exp_stall));
        check_val({tag, "_flush"}, {16'd0, flush_cnt}, 32'(exp_flush));
    endtask

    // Hold reset for two edges, then release. Through the boot window a
    // hazard, a redirect and a memory stall are all presented; all three
    // must be ignored.
    task automatic do_reset();
        drive(1'b1, 1'b0, 5'd0, NOP_INSTR, 1'b0, 1'b0);
        tick();
        tick();
        check_ctrl("rst_ctrl", C_BOOT);
        check_cnts("rst", 0, 0);
        drive(1'b0, 1'b1, 5'd5, ADD_X6_X5_X7, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check_ctrl($sformatf("boot%0d_ctrl", i), C_BOOT);
            tick();
        end
        check_cnts("boot_end", 0, 0);
    endtask

    initial begin
        drive(1'b1, 1'b0, 5'd0, NOP_INSTR, 1'b0, 1'b0);
        do_reset();

        // First RUN cycle: normal flow.
        drive(1'b0, 1'b0, 5'd0, NOP_INSTR, 1'b0, 1'b0);
        check_ctrl("run_normal", C_NORMAL);
        tick();

        // lw x5 in EX, add x6,x5,x7 in ID: one bubble.
        drive(1'b0, 1'b1, 5'd5, ADD_X6_X5_X7, 1'b0, 1'b0);
        check_ctrl("lu_rs1", C_BUBBLE);
        tick();
        check_cnts("lu_rs1", 1, 0);

        // Bubble now in EX: no stall.
        drive(1'b0, 1'b0, 5'd0, ADD_X6_X5_X7, 1'b0, 1'b0);
        check_ctrl("after_bubble", C_NORMAL);
        tick();

        // LUI has no register use.
        drive(1'b0, 1'b1, 5'd5, LUI_X5, 1'b0, 1'b0);
        check_ctrl("lui_no_use", C_NORMAL);
        tick();

        // rs1 = x0 and ex_rd = x0: never a hazard.
        drive(1'b0, 1'b1, 5'd0, ADDI_X1_X0_1, 1'b0, 1'b0);
        check_ctrl("x0_no_hz", C_NORMAL);
        tick();

        // I-type immediate bits alias rs2=x5, but rs2 is not read.
        drive(1'b0, 1'b1, 5'd5, ADDI_X1_X2_5, 1'b0, 1'b0);
        check_ctrl("itype_rs2_alias", C_NORMAL);
        tick();
        check_cnts("no_hz", 1, 0);

        // A store reads rs2=x5: hazard.
        drive(1'b0, 1'b1, 5'd5, SW_X5_0_X2, 1'b0, 1'b0);
        check_ctrl("lu_rs2", C_BUBBLE);
        tick();
        check_cnts("lu_rs2", 2, 0);

        // A redirect coincident with load_use wins.
        drive(1'b0, 1'b1, 5'd5, ADD_X6_X5_X7, 1'b1, 1'b0);
        check_ctrl("redir_vs_lu", C_REDIR);
        tick();
        check_cnts("redir_vs_lu", 2, 1);

        // Memory stall for 4 cycles during a load_use.
        drive(1'b0, 1'b1, 5'd5, ADD_X6_X5_X7, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check_ctrl($sformatf("freeze%0d", i), C_FREEZE);
            tick();
        end
        check_cnts("freeze", 2, 1);
        drive(1'b0, 1'b1, 5'd5, ADD_X6_X5_X7, 1'b0, 1'b0);
        check_ctrl("stall_release", C_BUBBLE);
        tick();
        check_cnts("stall_release", 3, 1);

        // A stall also holds a pending redirect.
        drive(1'b0, 1'b0, 5'd0, NOP_INSTR, 1'b1, 1'b1);
        check_ctrl("freeze_redir", C_FREEZE);
        tick();
        check_cnts("freeze_redir", 3, 1);

        // Saturation on the 2-bit counter: 1,2,3,3,3.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 5'd0, NOP_INSTR, 1'b1, 1'b0);
            check_ctrl($sformatf("sat_redir%0d", i), C_REDIR);
            tick();
            check_val($sformatf("sat_narrow%0d", i), {30'd0, n_flush_cnt},
                      (i < 3) ? 32'(i + 1) : 32'd3);
            check_val($sformatf("sat_wide%0d", i), {16'd0, flush_cnt},
                      32'(i + 1));
        end

        // Reset asserted mid-sequence, while a redirect is also presented.
        drive(1'b1, 1'b0, 5'd0, NOP_INSTR, 1'b1, 1'b0);
        tick();
        check_val("midrst_narrow", {30'd0, n_flush_cnt}, 32'd0);
        check_val("midrst_wide", {16'd0, flush_cnt}, 32'd0);
        check_val("midrst_boot", {31'd0, booting}, 32'd1);
        drive(1'b0, 1'b0, 5'd0, NOP_INSTR, 1'b0, 1'b0);
        check_ctrl("midrst_ctrl", C_BOOT);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Pipeline control unit for the 5-stage forwarding / predict-not-taken core.
- Decodes the ID-stage instruction's register usage from the same opcode classes the immediate generator uses.
- Detects load-use hazards against EX and applies taken-branch/jump redirects resolved in EX.
- Freezes the pipeline on data-memory stalls and runs a post-reset pipeline-flush sequence.
- Keeps saturating stall and flush event counters for debug.

Parameters:
BOOT_CYCLES, 3, cycles of forced pipeline flush after reset release (1..15)
CNT_W, 16, width of each event counter

Ports:
i_clk  input  1  clock, all state updates on rising edge
i_reset  input  1  synchronous, active-high reset
i_id_instr  input  32  instruction currently in the IF/ID register
i_ex_rd  input  5  destination register of the EX-stage instruction
i_ex_memrd  input  1  EX-stage instruction is a load (L opcode class)
i_ex_redirect  input  1  EX resolved taken branch, JAL or JALR (not-taken prediction failed)
i_mem_stall  input  1  data memory busy; whole pipeline must hold
o_pc_en  output  1  PC register write enable
o_pc_sel  output  1  1 = PC loads EX redirect target, 0 = PC+4
o_if_id_en  output  1  IF/ID register enable
o_if_id_flush  output  1  IF/ID register clears to NOP (0x00000013)
o_id_ex_en  output  1  ID/EX register enable
o_id_ex_flush  output  1  ID/EX register clears to bubble
o_ex_mem_en  output  1  EX/MEM and MEM/WB register enable
o_booting  output  1  high while in BOOT
o_stall_cnt  output  CNT_W  load-use bubbles inserted
o_flush_cnt  output  CNT_W  redirects applied

Behaviour:
- FSM states: BOOT, RUN.
- Registers: state, boot counter (4 bit), two counters.
- Control outputs are combinational from the state and current inputs (same-cycle effect).
- Reset (i_reset=1 at an edge): next state BOOT, boot counter = BOOT_CYCLES-1, o_stall_cnt = 0, o_flush_cnt = 0. Reset mid-run behaves identically; in-flight hazards are discarded.
- BOOT outputs:
  - o_pc_en=0, o_pc_sel=0, o_if_id_en=1, o_if_id_flush=1, o_id_ex_en=1, o_id_ex_flush=1, o_ex_mem_en=1, o_booting=1.
  - i_mem_stall, i_ex_redirect and hazards are ignored; counters do not count.
  - Boot counter decrements each cycle. The state moves to RUN on the edge where the counter is 0, so BOOT lasts exactly BOOT_CYCLES cycles.
- RUN default outputs: all enables=1, both flushes=0, o_pc_sel=0, o_booting=0.
- Register-use decode, on i_id_instr[6:2]:
  - uses rs1: R (01100), I (00100), L (00000), S (01000), SB (11000), JALR (11001).
  - uses rs2: R, S, SB.
  - LUI (01101), AUIPC (00101), JAL (11011) and unknown opcodes use none.
- load_use = i_ex_memrd & (i_ex_rd != 0) & ((uses_rs1 & rs1 == i_ex_rd) | (uses_rs2 & rs2 == i_ex_rd)).
- RUN priority, highest first:
  1. i_mem_stall: all enables=0, flushes=0, o_pc_sel=0. No counter change. A redirect or load-use presented that cycle is held in place and acted on once the stall drops.
  2. i_ex_redirect: o_pc_sel=1, o_pc_en=1, o_if_id_flush=1, o_id_ex_flush=1 (kills the 2 wrong-path instructions). o_flush_cnt +1. Any coincident load_use is ignored, because its ID instruction is being flushed.
  3. load_use: o_pc_en=0, o_if_id_en=0, o_id_ex_flush=1 (one bubble). o_stall_cnt +1. On the next cycle the load is in MEM and forwarding covers it, so exactly one bubble per load-use.
- Counters saturate at all-ones; no wrap.
- Exactly one of {freeze, redirect, bubble, normal} applies per RUN cycle.

Decomposition:
- Shared package pipe_pkg:
  - 5-bit opcode-class constants (R, I, S, L, SB, UL, UA, UJ, IJ), reused by the immediate generator and decoder.
  - NOP encoding constant.
  - State enum typedef {BOOT, RUN}.
- One sub-module, reg_use_decode: instr → uses_rs1, uses_rs2, rs1, rs2. Purely combinational, reusable by the forwarding unit.

Test Plan:
- Reset high 2 cycles, release with BOOT_CYCLES=3 → o_booting=1 and o_pc_en=0 for exactly 3 cycles, then RUN with all enables=1 and counters=0.
- EX lw x5 (i_ex_memrd=1, i_ex_rd=5), ID add x6,x5,x7 → o_pc_en=0, o_if_id_en=0, o_id_ex_flush=1 for one cycle; o_stall_cnt=1. The following cycle (EX = bubble) shows no stall.
- EX lw x5, ID lui x5,0x12345 (no rs use), then ID with rs1=x0 and i_ex_rd=0 → no stall either case; o_stall_cnt unchanged.
- i_ex_redirect=1 coincident with load_use → o_pc_sel=1, both flushes=1, o_pc_en=1; o_flush_cnt=1, o_stall_cnt unchanged.
- i_mem_stall=1 for 4 cycles during load_use → all enables 0 and counters frozen. On release, a single bubble is inserted; o_stall_cnt +1 only.
- CNT_W=2, 5 redirects → o_flush_cnt reads 1,2,3,3,3. Assert i_reset mid-sequence → counter 0 and BOOT re-entered next cycle.
